// File: rtl/ahb_slave_port_mux.sv
// ahb_slave_port_mux: steers the granted master onto one AHB slave and routes responses back
module ahb_slave_port_mux #(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                         hclk,
  input  logic                         hreset_n,
  input  logic [MASTER_NUM-1:0]        hgrant,
  input  logic [MASTER_NUM*ADDR_W-1:0] m_haddr,
  input  logic [MASTER_NUM*2-1:0]      m_htrans,
  input  logic [MASTER_NUM-1:0]        m_hwrite,
  input  logic [MASTER_NUM*3-1:0]      m_hsize,
  input  logic [MASTER_NUM*3-1:0]      m_hburst,
  input  logic [MASTER_NUM*DATA_W-1:0] m_hwdata,
  input  logic                         s_hreadyout,
  input  logic                         s_hresp,
  input  logic [DATA_W-1:0]            s_hrdata,
  output logic                         s_hsel,
  output logic [ADDR_W-1:0]            s_haddr,
  output logic [1:0]                   s_htrans,
  output logic                         s_hwrite,
  output logic [2:0]                   s_hsize,
  output logic [2:0]                   s_hburst,
  output logic [DATA_W-1:0]            s_hwdata,
  output logic [MASTER_NUM-1:0]        m_hready,
  output logic [MASTER_NUM-1:0]        m_hresp,
  output logic [DATA_W-1:0]            m_hrdata,
  output logic                         hwait,
  output logic [ERR_CNT_W-1:0]         err_count,
  output logic                         grant_err
);
  typedef enum logic [1:0] {DP_IDLE, DP_ACTIVE, DP_ERR} dp_state_t;
  dp_state_t state, state_nxt;
  logic [MASTER_NUM-1:0] dp_owner, grant_lo;
  logic [1:0] mux_trans;
  logic in_err, err_done, viol;
  // an illegal multi-bit grant resolves to its lowest set bit
  assign grant_lo = hgrant & (~hgrant + MASTER_NUM'(1));
  always_comb begin
    s_haddr   = '0;
    mux_trans = '0;
    s_hwrite  = 1'b0;
    s_hsize   = '0;
    s_hburst  = '0;
    s_hwdata  = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (grant_lo[i]) begin
        s_haddr   = m_haddr[i*ADDR_W +: ADDR_W];
        mux_trans = m_htrans[i*2 +: 2];
        s_hwrite  = m_hwrite[i];
        s_hsize   = m_hsize[i*3 +: 3];
        s_hburst  = m_hburst[i*3 +: 3];
      end
      if (dp_owner[i]) s_hwdata = m_hwdata[i*DATA_W +: DATA_W];
    end
  end
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) state <= DP_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = (state == DP_IDLE)   ? ((s_hreadyout & s_hsel) ? DP_ACTIVE : DP_IDLE)
              : (state == DP_ACTIVE) ? ((s_hresp & ~s_hreadyout) ? DP_ERR
                                       : s_hreadyout ? (s_hsel ? DP_ACTIVE : DP_IDLE) : DP_ACTIVE)
              : !s_hresp             ? DP_IDLE
              : s_hreadyout          ? (s_hsel ? DP_ACTIVE : DP_IDLE) : DP_ERR;
  end
  // the second error cycle cancels the burst, so no new address is offered
  always_comb begin
    in_err   = state == DP_ERR;
    err_done = in_err & s_hresp & s_hreadyout;
    viol     = in_err & ~s_hresp;
    s_htrans = in_err ? 2'b00 : mux_trans;
    s_hsel   = |hgrant & s_htrans[1];
  end
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) begin
      dp_owner  <= '0;
      err_count <= '0;
      grant_err <= 1'b0;
    end else begin
      if (viol) dp_owner <= '0;
      else if (s_hreadyout) dp_owner <= s_hsel ? grant_lo : '0;
      if (err_done && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
      if (|(hgrant & (hgrant - MASTER_NUM'(1)))) grant_err <= 1'b1;
    end
  assign m_hready = ~(dp_owner | hgrant) | {MASTER_NUM{s_hreadyout}};
  assign m_hresp  = dp_owner & {MASTER_NUM{s_hresp}};
  assign m_hrdata = s_hrdata;
  assign hwait    = |dp_owner & ~s_hreadyout;
endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// tb_ahb_slave_port_mux: directed vectors into a scoreboard queue, checked by a negedge monitor
module tb_ahb_slave_port_mux;
  logic hclk = 1'b0;
  logic hreset_n = 1'b1;
  logic [1:0]  hgrant;
  logic [63:0] m_haddr;
  logic [3:0]  m_htrans;
  logic [1:0]  m_hwrite;
  logic [5:0]  m_hsize, m_hburst;
  logic [63:0] m_hwdata;
  logic        s_hreadyout, s_hresp;
  logic [31:0] s_hrdata;
  logic        s_hsel, s_hwrite, hwait, grant_err;
  logic [31:0] s_haddr, s_hwdata, m_hrdata;
  logic [1:0]  s_htrans, m_hready, m_hresp;
  logic [2:0]  s_hsize, s_hburst;
  logic [7:0]  err_count;

  ahb_slave_port_mux dut (
    .hclk(hclk), .hreset_n(hreset_n), .hgrant(hgrant),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
    .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
    .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hwdata(s_hwdata),
    .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
    .hwait(hwait), .err_count(err_count), .grant_err(grant_err)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    string name;
    logic [31:0] hsel, addr, trans, wr, wdata, rdy, resp, hw, ec, ge, rdata;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(string n, string f, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", n, f, a, e);
    end
  endfunction

  task automatic push(string n, logic [31:0] hsel, logic [31:0] addr, logic [31:0] trans,
                      logic [31:0] wr, logic [31:0] wdata, logic [31:0] rdy, logic [31:0] resp,
                      logic [31:0] hw, logic [31:0] ec, logic [31:0] ge);
    exp_t e;
    e.name = n; e.hsel = hsel; e.addr = addr; e.trans = trans; e.wr = wr; e.wdata = wdata;
    e.rdy = rdy; e.resp = resp; e.hw = hw; e.ec = ec; e.ge = ge; e.rdata = s_hrdata;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drv(logic [1:0] g, logic rdy, logic resp);
    hgrant = g;
    s_hreadyout = rdy;
    s_hresp = resp;
    s_hrdata = s_hrdata + 32'h0101_0101;
  endtask

  initial begin
    forever begin
      @(negedge hclk);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk(e.name, "s_hsel",    32'(s_hsel),    e.hsel);
        chk(e.name, "s_haddr",   s_haddr,        e.addr);
        chk(e.name, "s_htrans",  32'(s_htrans),  e.trans);
        chk(e.name, "s_hwrite",  32'(s_hwrite),  e.wr);
        chk(e.name, "s_hwdata",  s_hwdata,       e.wdata);
        chk(e.name, "m_hready",  32'(m_hready),  e.rdy);
        chk(e.name, "m_hresp",   32'(m_hresp),   e.resp);
        chk(e.name, "hwait",     32'(hwait),     e.hw);
        chk(e.name, "err_count", 32'(err_count), e.ec);
        chk(e.name, "grant_err", 32'(grant_err), e.ge);
        chk(e.name, "m_hrdata",  m_hrdata,       e.rdata);
      end
    end
  end

  initial begin
    m_haddr  = {32'h0000_2000, 32'h0000_1000};
    m_htrans = {2'b10, 2'b10};
    m_hwrite = 2'b01;
    m_hsize  = {3'd2, 3'd2};
    m_hburst = {3'd1, 3'd0};
    m_hwdata = {32'hCAFE_F00D, 32'hDEAD_BEEF};
    hgrant = 2'b00; s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = 32'h1234_0000;
    #1 hreset_n = 1'b0;
    step(); step();
    push("reset", 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    step(); hreset_n = 1'b1;
    drv(2'b01, 1, 0); push("single_addr", 1, 'h1000, 2, 1, 0, 3, 0, 0, 0, 0);
    step(); drv(2'b00, 1, 0); push("single_data", 0, 0, 0, 0, 'hDEADBEEF, 3, 0, 0, 0, 0);
    step(); drv(2'b10, 1, 0); push("m1_addr", 1, 'h2000, 2, 0, 0, 3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); drv(2'b00, 0, 0); push("wait", 0, 0, 0, 0, 'hCAFEF00D, 1, 0, 1, 0, 0);
    end
    step(); drv(2'b00, 1, 0); push("wait_done", 0, 0, 0, 0, 'hCAFEF00D, 3, 0, 0, 0, 0);
    step(); drv(2'b01, 1, 0); push("ho_m0_addr", 1, 'h1000, 2, 1, 0, 3, 0, 0, 0, 0);
    step(); drv(2'b10, 1, 0); push("ho_overlap", 1, 'h2000, 2, 0, 'hDEADBEEF, 3, 0, 0, 0, 0);
    step(); drv(2'b00, 1, 0); push("ho_m1_data", 0, 0, 0, 0, 'hCAFEF00D, 3, 0, 0, 0, 0);
    step(); drv(2'b01, 1, 0); push("err_addr", 1, 'h1000, 2, 1, 0, 3, 0, 0, 0, 0);
    step(); drv(2'b01, 0, 1); push("err_cyc1", 1, 'h1000, 2, 1, 'hDEADBEEF, 2, 1, 1, 0, 0);
    step(); drv(2'b01, 1, 1); push("err_cyc2", 0, 'h1000, 0, 1, 'hDEADBEEF, 3, 1, 0, 0, 0);
    step(); drv(2'b00, 1, 0); push("err_done", 0, 0, 0, 0, 0, 3, 0, 0, 1, 0);
    step(); drv(2'b01, 1, 0); push("viol_addr", 1, 'h1000, 2, 1, 0, 3, 0, 0, 1, 0);
    step(); drv(2'b00, 0, 1); push("viol_err1", 0, 0, 0, 0, 'hDEADBEEF, 2, 1, 1, 1, 0);
    step(); drv(2'b00, 0, 0); push("viol_drop", 0, 0, 0, 0, 'hDEADBEEF, 2, 0, 1, 1, 0);
    step(); drv(2'b00, 0, 0); push("viol_after", 0, 0, 0, 0, 0, 3, 0, 0, 1, 0);
    for (int i = 0; i < 254; i++) begin
      step(); drv(2'b01, 1, 0);
      step(); drv(2'b01, 0, 1);
      step(); drv(2'b01, 1, 1);
    end
    step(); drv(2'b00, 1, 0); push("err_sat", 0, 0, 0, 0, 0, 3, 0, 0, 'hFF, 0);
    step(); drv(2'b01, 1, 0);
    step(); drv(2'b01, 0, 1);
    step(); drv(2'b01, 1, 1); push("err_hold_c2", 0, 'h1000, 0, 1, 'hDEADBEEF, 3, 1, 0, 'hFF, 0);
    step(); drv(2'b00, 1, 0); push("err_hold", 0, 0, 0, 0, 0, 3, 0, 0, 'hFF, 0);
    step(); drv(2'b11, 1, 0); push("gnt_multi", 1, 'h1000, 2, 1, 0, 3, 0, 0, 'hFF, 0);
    step(); drv(2'b00, 1, 0); push("gnt_sticky", 0, 0, 0, 0, 'hDEADBEEF, 3, 0, 0, 'hFF, 1);
    step(); drv(2'b00, 1, 0); push("gnt_hold", 0, 0, 0, 0, 0, 3, 0, 0, 'hFF, 1);
    step(); drv(2'b01, 1, 0); push("rst_addr", 1, 'h1000, 2, 1, 0, 3, 0, 0, 'hFF, 1);
    step(); drv(2'b00, 0, 0); push("rst_wait", 0, 0, 0, 0, 'hDEADBEEF, 2, 0, 1, 'hFF, 1);
    step(); hreset_n = 1'b0; push("rst_mid", 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    repeat (4) @(negedge hclk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_slave_port_mux.md
Name: ahb_slave_port_mux

Overview:
Slave-side address/data routing stage that sits directly downstream of the per-slave arbiter (AHB_arbiter_slave_N).
- Uses the arbiter's one-hot `hgrant` to steer the winning master's address-phase signals onto the slave.
- Tracks which master owns the data phase and steers that master's write data to the slave.
- Returns HREADY/HRESP to the masters, and returns `hwait` to the arbiter so grants stall on slave wait states.

Parameters:
MASTER_NUM, 2, number of masters that can reach this slave (matches the arbiter's SLAVE_X_MASTER_NUM).
ADDR_W, 32, address width.
DATA_W, 32, data bus width.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
hclk  in  1  system clock, rising edge.
hreset_n  in  1  reset, asynchronous assert, active-low.
hgrant  in  MASTER_NUM  one-hot grant from the arbiter; all-zero means no owner.
m_haddr  in  MASTER_NUM*ADDR_W  master addresses, packed; master i at [i*ADDR_W +: ADDR_W].
m_htrans  in  MASTER_NUM*2  master HTRANS, packed.
m_hwrite  in  MASTER_NUM  master HWRITE.
m_hsize  in  MASTER_NUM*3  master HSIZE, packed.
m_hburst  in  MASTER_NUM*3  master HBURST (burst_type encoding), packed.
m_hwdata  in  MASTER_NUM*DATA_W  master write data, packed.
s_hreadyout  in  1  slave ready.
s_hresp  in  1  slave response; 1 = ERROR.
s_hrdata  in  DATA_W  slave read data.
s_hsel  out  1  slave select.
s_haddr  out  ADDR_W  muxed address.
s_htrans  out  2  muxed HTRANS.
s_hwrite  out  1  muxed HWRITE.
s_hsize  out  3  muxed HSIZE.
s_hburst  out  3  muxed HBURST; also fed to the arbiter's `hburst` input.
s_hwdata  out  DATA_W  write data of the data-phase owner.
m_hready  out  MASTER_NUM  per-master HREADY.
m_hresp  out  MASTER_NUM  per-master HRESP.
m_hrdata  out  DATA_W  read data, broadcast to all masters.
hwait  out  1  to the arbiter: data phase active and slave not ready.
err_count  out  ERR_CNT_W  saturating count of completed ERROR responses.
grant_err  out  1  sticky flag: `hgrant` was seen with more than one bit set.

Behaviour:
Address phase (combinational):
- sel = index of the set bit of `hgrant`.
- s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst = master[sel] fields.
- If `hgrant` is all-zero, these outputs are 0 (s_htrans = IDLE = 2'b00).
- s_hsel = |hgrant & s_htrans[1] (NONSEQ or SEQ).

Data-phase owner register `dp_owner` (MASTER_NUM bits, one-hot or zero):
- On a clock edge with s_hreadyout=1: dp_owner <= (s_hsel ? hgrant : 0).
- Otherwise dp_owner holds.
- s_hwdata = m_hwdata of dp_owner; 0 if dp_owner = 0.

Master returns:
- m_hready[i] = s_hreadyout if (dp_owner[i] | hgrant[i]); otherwise 1.
- m_hresp[i] = s_hresp if dp_owner[i]; otherwise 0.
- m_hrdata = s_hrdata, broadcast.
- hwait = (dp_owner != 0) & ~s_hreadyout.

Data-phase FSM, states DP_IDLE, DP_ACTIVE, DP_ERR:
- DP_IDLE -> DP_ACTIVE: s_hreadyout=1 and s_hsel=1.
- DP_ACTIVE -> DP_ERR: s_hresp=1 and s_hreadyout=0 (first cycle of ERROR).
- DP_ACTIVE -> DP_IDLE: s_hreadyout=1 and s_hsel=0.
- DP_ACTIVE stays DP_ACTIVE: s_hreadyout=1 and s_hsel=1 (back-to-back transfers).
- DP_ERR -> (s_hsel ? DP_ACTIVE : DP_IDLE): s_hreadyout=1 and s_hresp=1. On this edge err_count increments, saturating at all-ones.
- DP_ERR, protocol violation: s_hresp drops to 0 while still in DP_ERR -> go to DP_IDLE, clear dp_owner, no err_count increment.
- While in DP_ERR, s_htrans is forced to IDLE and s_hsel to 0, so the erroring burst is cancelled and no new address is accepted during the 2nd error cycle.

grant_err:
- Set when $countones(hgrant) > 1.
- Cleared only by reset.
- While more than one bit is set, the lowest set bit wins the mux.

Reset (asynchronous, active-low), registers:
- dp_owner = 0, state = DP_IDLE, err_count = 0, grant_err = 0.

Reset, outputs with hgrant=0:
- s_* = 0.
- m_hready = all 1.
- m_hresp = 0.
- hwait = 0.

Reset asserted mid-transfer: the owner is dropped immediately and no partial state survives.

Latency:
- Address path: 0 cycles.
- Data-phase ownership: 1 cycle after the address phase completes (s_hreadyout=1).

Test Plan:
- Single write: hgrant=01, m0 NONSEQ haddr=0x1000, s_hreadyout=1 -> s_haddr=0x1000, s_hsel=1; next cycle dp_owner=01 and s_hwdata=m0 hwdata=0xDEADBEEF.
- Wait states: master1 read, s_hreadyout=0 for 3 cycles, then 1 -> hwait=1 and m_hready[1]=0 for 3 cycles; m_hready[0]=1 throughout; dp_owner holds 10.
- Pipelined handover: m0 last beat in data phase while hgrant=10 presents m1 NONSEQ at 0x2000 -> s_hwdata from m0 and s_haddr=0x2000 in the same cycle; next cycle dp_owner=10.
- ERROR response: slave drives hresp=1/hreadyout=0, then hresp=1/hreadyout=1 -> state DP_ACTIVE -> DP_ERR -> DP_IDLE; m_hresp[owner]=1 both cycles; s_htrans=IDLE in the 2nd cycle; err_count 0 -> 1. Repeat 256 times -> err_count saturates at 0xFF.
- Illegal grant: hgrant=11 -> grant_err=1 and stays 1; mux selects m0.
- Reset mid-burst: assert hreset_n=0 during DP_ACTIVE -> dp_owner=0, hwait=0, m_hready=11 asynchronously, before the next clock edge.
